// File: rtl/rf_write_scheduler.sv
// Dual-port register-file write scheduler with in-order pending FIFO.
// Optional forwarding lookup on the pending writes: define ARB_FWD_EN.
module rf_write_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 8,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  req11_i,
    input  logic                  req12_i,
    input  logic                  req21_i,
    input  logic                  req22_i,
    input  logic [ADDR_WIDTH-1:0] addr11_i,
    input  logic [ADDR_WIDTH-1:0] addr12_i,
    input  logic [ADDR_WIDTH-1:0] addr21_i,
    input  logic [ADDR_WIDTH-1:0] addr22_i,
    input  logic [DATA_WIDTH-1:0] data11_i,
    input  logic [DATA_WIDTH-1:0] data12_i,
    input  logic [DATA_WIDTH-1:0] data21_i,
    input  logic [DATA_WIDTH-1:0] data22_i,
    output logic                  stall_o,
    output logic                  wr0_en_o,
    output logic                  wr1_en_o,
    output logic [ADDR_WIDTH-1:0] wr0_addr_o,
    output logic [ADDR_WIDTH-1:0] wr1_addr_o,
    output logic [DATA_WIDTH-1:0] wr0_data_o,
    output logic [DATA_WIDTH-1:0] wr1_data_o,
    output logic [CW-1:0]         pending_o
`ifdef ARB_FWD_EN
    ,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_hit_o,
    output logic [DATA_WIDTH-1:0] rd_data_o
`endif
);

    // Pointer advance modulo DEPTH; off never exceeds DEPTH so one fold suffices.
    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p,
                                           input logic [PW:0]   off);
        logic [PW:0] s;
        s = {1'b0, p} + off;
        if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
        return s[PW-1:0];
    endfunction

    logic [ADDR_WIDTH-1:0] fa_q [DEPTH];
    logic [DATA_WIDTH-1:0] fd_q [DEPTH];
    logic [PW-1:0]         rp_q, rp_d, wp_q, wp_d, rp1;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  wr0_en_q, wr0_en_d, wr1_en_q, wr1_en_d;
    logic [ADDR_WIDTH-1:0] wr0_addr_q, wr0_addr_d, wr1_addr_q, wr1_addr_d;
    logic [DATA_WIDTH-1:0] wr0_data_q, wr0_data_d, wr1_data_q, wr1_data_d;

    logic [5:0]                 cv, gm;
    logic [5:0][ADDR_WIDTH-1:0] ca;
    logic [5:0][DATA_WIDTH-1:0] cd;
    logic                       accept, fifo_on;
    logic                       found0, found1, gnt0, gnt1;
    int                         i0, i1;
    logic [ADDR_WIDTH-1:0]      a0, a1;
    logic [DATA_WIDTH-1:0]      d0, d1;
    logic [1:0]                 pops;
    logic [2:0]                 pushes;
    logic [3:0]                 push_en;
    logic [3:0][PW-1:0]         push_idx;

    assign stall_o   = cnt_q > CW'(DEPTH - 4);
    assign pending_o = cnt_q;
    assign rp1       = wrap(rp_q, (PW+1)'(1));

    always_comb begin
        fifo_on = !flush_i;
        accept  = !stall_o && !flush_i;
        cv[0] = fifo_on && (cnt_q != '0);
        cv[1] = fifo_on && (cnt_q >= CW'(2));
        cv[2] = accept && req11_i;
        cv[3] = accept && req12_i;
        cv[4] = accept && req21_i;
        cv[5] = accept && req22_i;
        ca[0] = fa_q[rp_q];
        ca[1] = fa_q[rp1];
        ca[2] = addr11_i;
        ca[3] = addr12_i;
        ca[4] = addr21_i;
        ca[5] = addr22_i;
        cd[0] = fd_q[rp_q];
        cd[1] = fd_q[rp1];
        cd[2] = data11_i;
        cd[3] = data12_i;
        cd[4] = data21_i;
        cd[5] = data22_i;
    end

    // First two valid candidates in program order; second loses on same reg.
    always_comb begin
        found0 = 1'b0;
        found1 = 1'b0;
        i0     = 0;
        i1     = 0;
        a0     = '0;
        a1     = '0;
        d0     = '0;
        d1     = '0;
        for (int i = 0; i < 6; i++) begin
            if (cv[i]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    i0     = i;
                    a0     = ca[i];
                    d0     = cd[i];
                end else if (!found1) begin
                    found1 = 1'b1;
                    i1     = i;
                    a1     = ca[i];
                    d1     = cd[i];
                end
            end
        end
        gnt0 = found0;
        gnt1 = found1 && (a1 != a0);
        for (int i = 0; i < 6; i++) begin
            gm[i] = (gnt0 && (i == i0)) || (gnt1 && (i == i1));
        end
    end

    always_comb begin
        pops   = 2'(gm[0]) + 2'(gm[1]);
        pushes = '0;
        for (int j = 0; j < 4; j++) begin
            push_en[j]  = cv[j+2] && !gm[j+2];
            push_idx[j] = wrap(wp_q, (PW+1)'(pushes));
            pushes      = pushes + 3'(push_en[j]);
        end
        cnt_d = cnt_q - CW'(pops) + CW'(pushes);
        rp_d  = wrap(rp_q, (PW+1)'(pops));
        wp_d  = wrap(wp_q, (PW+1)'(pushes));
        if (flush_i) begin
            cnt_d = '0;
            rp_d  = '0;
            wp_d  = '0;
        end
        wr0_en_d   = gnt0;
        wr1_en_d   = gnt1;
        wr0_addr_d = gnt0 ? a0 : wr0_addr_q;
        wr0_data_d = gnt0 ? d0 : wr0_data_q;
        wr1_addr_d = gnt1 ? a1 : wr1_addr_q;
        wr1_data_d = gnt1 ? d1 : wr1_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q       <= '0;
            wp_q       <= '0;
            cnt_q      <= '0;
            wr0_en_q   <= 1'b0;
            wr1_en_q   <= 1'b0;
            wr0_addr_q <= '0;
            wr1_addr_q <= '0;
            wr0_data_q <= '0;
            wr1_data_q <= '0;
        end else begin
            rp_q       <= rp_d;
            wp_q       <= wp_d;
            cnt_q      <= cnt_d;
            wr0_en_q   <= wr0_en_d;
            wr1_en_q   <= wr1_en_d;
            wr0_addr_q <= wr0_addr_d;
            wr1_addr_q <= wr1_addr_d;
            wr0_data_q <= wr0_data_d;
            wr1_data_q <= wr1_data_d;
        end
    end

    // Entry storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (push_en[j]) begin
                fa_q[push_idx[j]] <= ca[j+2];
                fd_q[push_idx[j]] <= cd[j+2];
            end
        end
    end

    assign wr0_en_o   = wr0_en_q;
    assign wr1_en_o   = wr1_en_q;
    assign wr0_addr_o = wr0_addr_q;
    assign wr1_addr_o = wr1_addr_q;
    assign wr0_data_o = wr0_data_q;
    assign wr1_data_o = wr1_data_q;

`ifdef ARB_FWD_EN
    logic [PW-1:0] fidx;

    // Later assignments win: FIFO oldest..youngest, then wr0, then wr1.
    always_comb begin
        rd_hit_o  = 1'b0;
        rd_data_o = '0;
        fidx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = wrap(rp_q, (PW+1)'(k));
            if ((CW'(k) < cnt_q) && (fa_q[fidx] == rd_addr_i)) begin
                rd_hit_o  = 1'b1;
                rd_data_o = fd_q[fidx];
            end
        end
        if (wr0_en_q && (wr0_addr_q == rd_addr_i)) begin
            rd_hit_o  = 1'b1;
            rd_data_o = wr0_data_q;
        end
        if (wr1_en_q && (wr1_addr_q == rd_addr_i)) begin
            rd_hit_o  = 1'b1;
            rd_data_o = wr1_data_q;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Scoreboard bench for rf_write_scheduler: program-order queue of expected
// writes plus a small pending-FIFO model for stall/occupancy/enables.
module tb_rf_write_scheduler;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          req11_i = 1'b0, req12_i = 1'b0, req21_i = 1'b0, req22_i = 1'b0;
    logic [AW-1:0] addr11_i = '0, addr12_i = '0, addr21_i = '0, addr22_i = '0;
    logic [DW-1:0] data11_i = '0, data12_i = '0, data21_i = '0, data22_i = '0;
    logic          stall_o, wr0_en_o, wr1_en_o;
    logic [AW-1:0] wr0_addr_o, wr1_addr_o;
    logic [DW-1:0] wr0_data_o, wr1_data_o;
    logic [CW-1:0] pending_o;
`ifdef ARB_FWD_EN
    logic [AW-1:0] rd_addr_i = '0;
    logic          rd_hit_o;
    logic [DW-1:0] rd_data_o;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           mq[$];
    wr_t           sb[$];
    int            tests = 0;
    int            failed = 0;
    logic [AW-1:0] av[4];
    logic [DW-1:0] dv[4];

    rf_write_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .req11_i(req11_i), .req12_i(req12_i), .req21_i(req21_i), .req22_i(req22_i),
        .addr11_i(addr11_i), .addr12_i(addr12_i),
        .addr21_i(addr21_i), .addr22_i(addr22_i),
        .data11_i(data11_i), .data12_i(data12_i),
        .data21_i(data21_i), .data22_i(data22_i),
        .stall_o(stall_o),
        .wr0_en_o(wr0_en_o), .wr1_en_o(wr1_en_o),
        .wr0_addr_o(wr0_addr_o), .wr1_addr_o(wr1_addr_o),
        .wr0_data_o(wr0_data_o), .wr1_data_o(wr1_data_o),
        .pending_o(pending_o)
`ifdef ARB_FWD_EN
        ,
        .rd_addr_i(rd_addr_i), .rd_hit_o(rd_hit_o), .rd_data_o(rd_data_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input logic [3:0] rq, input logic fl);
        wr_t cand[$];
        wr_t e;
        bit  es;
        int  n;
        req11_i = rq[0]; req12_i = rq[1]; req21_i = rq[2]; req22_i = rq[3];
        addr11_i = av[0]; addr12_i = av[1]; addr21_i = av[2]; addr22_i = av[3];
        data11_i = dv[0]; data12_i = dv[1]; data21_i = dv[2]; data22_i = dv[3];
        flush_i = fl;
        #1;
        es = (mq.size() > DEPTH - 4);
        tests++;
        if (stall_o !== es) begin
            failed++;
            $display("FAIL stall: got %b want %b", stall_o, es);
        end
        if (fl) begin
            mq.delete();
            sb.delete();
        end
        cand = mq;
        if (!es && !fl) begin
            for (int i = 0; i < 4; i++) begin
                if (rq[i]) begin
                    e.a = av[i];
                    e.d = dv[i];
                    cand.push_back(e);
                    sb.push_back(e);
                end
            end
        end
        n = 0;
        if (cand.size() >= 1) n = 1;
        if (cand.size() >= 2 && cand[1].a != cand[0].a) n = 2;
        for (int i = 0; i < n; i++) void'(cand.pop_front());
        mq = cand;
        @(posedge clk);
        #1;
        tests++;
        if (wr0_en_o !== (n >= 1) || wr1_en_o !== (n == 2)) begin
            failed++;
            $display("FAIL enables: got %b%b want %b%b",
                     wr0_en_o, wr1_en_o, n >= 1, n == 2);
        end
        tests++;
        if (pending_o !== CW'(mq.size())) begin
            failed++;
            $display("FAIL pending: got %0d want %0d", pending_o, mq.size());
        end
        if (wr0_en_o === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL wr0 extra: got a=%0d d=%h want none",
                         wr0_addr_o, wr0_data_o);
            end else begin
                e = sb.pop_front();
                if ({wr0_addr_o, wr0_data_o} !== e) begin
                    failed++;
                    $display("FAIL wr0 order: got a=%0d d=%h want a=%0d d=%h",
                             wr0_addr_o, wr0_data_o, e.a, e.d);
                end
            end
        end
        if (wr1_en_o === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL wr1 extra: got a=%0d d=%h want none",
                         wr1_addr_o, wr1_data_o);
            end else begin
                e = sb.pop_front();
                if ({wr1_addr_o, wr1_data_o} !== e) begin
                    failed++;
                    $display("FAIL wr1 order: got a=%0d d=%h want a=%0d d=%h",
                             wr1_addr_o, wr1_data_o, e.a, e.d);
                end
            end
        end
        flush_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 16; k++) begin
            if (mq.size() > 0) step(4'b0000, 1'b0);
        end
        tests++;
        if (sb.size() != 0 || pending_o !== '0 || stall_o !== 1'b0) begin
            failed++;
            $display("FAIL drain: got left=%0d pend=%0d stall=%b want 0 0 0",
                     sb.size(), pending_o, stall_o);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        tests++;
        if (wr0_en_o !== 1'b0 || wr1_en_o !== 1'b0 || wr0_addr_o !== '0 ||
            wr1_addr_o !== '0 || wr0_data_o !== '0 || wr1_data_o !== '0 ||
            pending_o !== '0 || stall_o !== 1'b0) begin
            failed++;
            $display("FAIL %s: got en=%b%b a=%0d,%0d d=%h,%h p=%0d s=%b want all 0",
                     nm, wr0_en_o, wr1_en_o, wr0_addr_o, wr1_addr_o,
                     wr0_data_o, wr1_data_o, pending_o, stall_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        mq.delete();
        sb.delete();
    endtask

    task automatic test_single();
        av = '{5'd3, 5'd0, 5'd0, 5'd0};
        dv = '{32'hA5, 32'h0, 32'h0, 32'h0};
        step(4'b0001, 1'b0);
        tests++;
        if (wr0_en_o !== 1'b1 || wr0_addr_o !== 5'd3 || wr0_data_o !== 32'hA5 ||
            wr1_en_o !== 1'b0 || pending_o !== '0) begin
            failed++;
            $display("FAIL single: got en=%b a=%0d d=%h en1=%b p=%0d want 1 3 a5 0 0",
                     wr0_en_o, wr0_addr_o, wr0_data_o, wr1_en_o, pending_o);
        end
    endtask

    task automatic test_all_four();
        av = '{5'd1, 5'd2, 5'd3, 5'd4};
        dv = '{32'h101, 32'h102, 32'h103, 32'h104};
        step(4'b1111, 1'b0);
        tests++;
        if (wr0_addr_o !== 5'd1 || wr1_addr_o !== 5'd2 || pending_o !== CW'(2)) begin
            failed++;
            $display("FAIL four_c1: got a=%0d,%0d p=%0d want 1,2 p=2",
                     wr0_addr_o, wr1_addr_o, pending_o);
        end
        step(4'b0000, 1'b0);
        tests++;
        if (wr0_addr_o !== 5'd3 || wr1_addr_o !== 5'd4 || pending_o !== '0) begin
            failed++;
            $display("FAIL four_c2: got a=%0d,%0d p=%0d want 3,4 p=0",
                     wr0_addr_o, wr1_addr_o, pending_o);
        end
    endtask

    task automatic test_same_addr();
        av = '{5'd7, 5'd7, 5'd0, 5'd0};
        dv = '{32'h1, 32'h2, 32'h0, 32'h0};
        step(4'b0011, 1'b0);
        tests++;
        if (wr0_data_o !== 32'h1 || wr1_en_o !== 1'b0) begin
            failed++;
            $display("FAIL same_c1: got d=%h en1=%b want 1 0", wr0_data_o, wr1_en_o);
        end
        step(4'b0000, 1'b0);
        tests++;
        if (wr0_en_o !== 1'b1 || wr0_addr_o !== 5'd7 || wr0_data_o !== 32'h2) begin
            failed++;
            $display("FAIL same_c2: got en=%b a=%0d d=%h want 1 7 2",
                     wr0_en_o, wr0_addr_o, wr0_data_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                tests++;
                if (stall_o !== 1'b1 || pending_o !== CW'(6)) begin
                    failed++;
                    $display("FAIL stall_point: got s=%b p=%0d want 1 6",
                             stall_o, pending_o);
                end
            end
            for (int i = 0; i < 4; i++) begin
                av[i] = AW'(c * 4 + i + 1);
                dv[i] = $urandom;
            end
            step(4'b1111, 1'b0);
        end
        drain();
    endtask

    task automatic test_flush_reset();
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        av = '{5'd8, 5'd9, 5'd10, 5'd11};
        dv = '{32'h8, 32'h9, 32'hA, 32'hB};
        step(4'b1111, 1'b0);
        av = '{5'd12, 5'd13, 5'd14, 5'd15};
        dv = '{32'hC, 32'hD, 32'hE, 32'hF};
        step(4'b1111, 1'b0);
        tests++;
        if (pending_o !== CW'(4)) begin
            failed++;
            $display("FAIL flush_pre: got p=%0d want 4", pending_o);
        end
        a0 = wr0_addr_o; d0 = wr0_data_o;
        a1 = wr1_addr_o; d1 = wr1_data_o;
        step(4'b1111, 1'b1);
        tests++;
        if (pending_o !== '0 || wr0_en_o !== 1'b0 || wr1_en_o !== 1'b0 ||
            wr0_addr_o !== a0 || wr0_data_o !== d0 ||
            wr1_addr_o !== a1 || wr1_data_o !== d1) begin
            failed++;
            $display("FAIL flush: got p=%0d en=%b%b a=%0d,%0d want p=0 en=00 a=%0d,%0d held",
                     pending_o, wr0_en_o, wr1_en_o, wr0_addr_o, wr1_addr_o, a0, a1);
        end
        av = '{5'd16, 5'd17, 5'd18, 5'd19};
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        req11_i = 1'b1; req12_i = 1'b1; req21_i = 1'b1; req22_i = 1'b1;
        flush_i = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("rst_mid");
        rst = 1'b0;
        flush_i = 1'b0;
        mq.delete();
        sb.delete();
        step(4'b0000, 1'b0);
    endtask

`ifdef ARB_FWD_EN
    task automatic test_fwd();
        av = '{5'd1, 5'd2, 5'd5, 5'd5};
        dv = '{32'h1, 32'h2, 32'h10, 32'h20};
        step(4'b1111, 1'b0);
        rd_addr_i = 5'd5;
        #1;
        tests++;
        if (rd_hit_o !== 1'b1 || rd_data_o !== 32'h20) begin
            failed++;
            $display("FAIL fwd_hit: got %b %h want 1 20", rd_hit_o, rd_data_o);
        end
        rd_addr_i = 5'd9;
        #1;
        tests++;
        if (rd_hit_o !== 1'b0 || rd_data_o !== '0) begin
            failed++;
            $display("FAIL fwd_miss: got %b %h want 0 0", rd_hit_o, rd_data_o);
        end
        rd_addr_i = 5'd2;
        #1;
        tests++;
        if (rd_hit_o !== 1'b1 || rd_data_o !== 32'h2) begin
            failed++;
            $display("FAIL fwd_wr1: got %b %h want 1 2", rd_hit_o, rd_data_o);
        end
        drain();
    endtask
`endif

    initial begin
        av = '{default: '0};
        dv = '{default: '0};
        test_reset();
        test_single();
        test_all_four();
        test_same_addr();
        test_back_to_back();
        test_flush_reset();
`ifdef ARB_FWD_EN
        test_fwd();
`endif
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
